// File: rtl/radix4_booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, WIDTH/2+1 digits per product.
// Handles signed and unsigned operands by extending both to WIDTH+2 bits before recoding.
module radix4_booth_mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int M  = WIDTH / 2 + 1;
    localparam int EW = WIDTH + 2;
    localparam int PW = 2 * WIDTH + 4;
    localparam int CW = $clog2(M + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mcand;
    logic [EW-1:0]   mplier;
    logic            prev;
    logic [CW-1:0]   cnt;

    logic [EW-1:0]   a_ext;
    logic [EW-1:0]   b_ext;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   sum;

    // Two extra bits keep unsigned operands positive under Booth recoding.
    assign a_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign b_ext = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

    always_comb begin
        pp = '0;
        case ({mplier[1:0], prev})
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
    end

    assign sum = acc + pp;

    // The multiplicand shifts left while the multiplier shifts right, so
    // each digit lands at its correct weight without a variable shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            prev    <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{(PW-EW){a_ext[EW-1]}}, a_ext};
                        mplier <= b_ext;
                        prev   <= 1'b0;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= sum;
                    mcand  <= mcand << 2;
                    mplier <= mplier >> 2;
                    prev   <= mplier[1];
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(M - 1)) begin
                        product <= sum[2*WIDTH-1:0];
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_radix4_booth_mult_seq.sv
// Self-checking bench for radix4_booth_mult_seq (WIDTH=16): directed corner cases,
// stall and reset scenarios, then randomized operands against an arithmetic reference.
module tb_radix4_booth_mult_seq;

    localparam int WIDTH = 16;
    localparam int M     = WIDTH / 2 + 1;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                signed_mode;
    logic                out_valid;
    logic                out_ready;
    logic [2*WIDTH-1:0]  product;
    logic                busy;

    int n_vec;
    int n_err;

    radix4_booth_mult_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer multiply of the operands read in the requested mode.
    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic sm);
        longint xv;
        longint yv;
        longint pv;
        xv = sm ? longint'($signed(x)) : longint'(x);
        yv = sm ? longint'($signed(y)) : longint'(y);
        pv = xv * yv;
        return pv[31:0];
    endfunction

    // Issue one operation, check latency and result, stall for 'stall' cycles, then drain.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic sm,
                         input int stall, input logic poke, input logic [31:0] exp);
        int lat;
        logic [31:0] held;
        @(negedge clk);
        check("in_ready_before_issue", in_ready, 1'b1);
        in_valid    = 1'b1;
        a           = x;
        b           = y;
        signed_mode = sm;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        a           = 16'($urandom);
        b           = 16'($urandom);
        signed_mode = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            a           = 16'($urandom);
            b           = 16'($urandom);
            signed_mode = 1'($urandom);
        end
        check("latency", 64'(lat), 64'(M));
        check("product", product, exp);
        held = product;
        for (int k = 0; k < stall; k++) begin
            if (poke) begin
                in_valid = 1'b1;
                a        = 16'($urandom);
                b        = 16'($urandom);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (poke) begin
                check("stall_out_valid", out_valid, 1'b1);
                check("stall_product", product, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_xfer", in_ready, 1'b1);
        check("product_retained", product, held);
        $display("op a=%04h b=%04h sm=%0d stall=%0d -> product=%08h (exp %08h)", x, y, sm, stall, held, exp);
    endtask

    initial begin
        logic [15:0] rx;
        logic [15:0] ry;
        logic        rs;
        logic        seen;
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        out_ready   = 1'b0;
        #12;
        check("rst_product", product, 32'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        do_op(16'h0001, 16'h0001, 1'b1, 0, 1'b0, 32'h00000001);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0, 32'h00000001);
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0, 32'hFFFE0001);
        do_op(16'h1234, 16'hFEDC, 1'b1, 0, 1'b0, 32'hFFEB3CB0);
        do_op(16'h7FFF, 16'h8000, 1'b1, 0, 1'b0, 32'hC0008000);
        do_op(16'h8000, 16'h8000, 1'b1, 0, 1'b0, 32'h40000000);
        do_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0, 32'h40000000);
        do_op(16'h0000, 16'hABCD, 1'b1, 0, 1'b0, 32'h00000000);
        do_op(16'hABCD, 16'h0000, 1'b0, 0, 1'b0, 32'h00000000);
        // Long stall with ignored input pulses.
        do_op(16'h1234, 16'hFEDC, 1'b0, 20, 1'b1, 32'h121F3CB0);

        // Reset four cycles after acceptance.
        @(negedge clk);
        in_valid    = 1'b1;
        a           = 16'h00FF;
        b           = 16'h0101;
        signed_mode = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_product", product, 32'h0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_out_valid", seen, 1'b0);
        do_op(16'h0123, 16'hFF00, 1'b1, 1, 1'b0, 32'hFFFEDD00);

        // Randomized operands with random consumer stalls.
        for (int i = 0; i < 1000; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rs = 1'($urandom);
            case ($urandom_range(0, 7))
                0: rx = 16'h8000;
                1: ry = 16'hFFFF;
                2: rx = 16'h7FFF;
                default: ;
            endcase
            do_op(rx, ry, rs, int'($urandom_range(0, 3)), 1'b0, ref_mul(rx, ry, rs));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
